// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames and
// turns E0/F0-prefixed scan codes into make/break events with a held-key vector.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [8:0]   last_change,
  output logic         key_down_onepulse,
  output logic         key_up_onepulse,
  output logic [511:0] key_down,
  output logic         frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
  logic ps2_dat_s1_q, ps2_dat_s2_q;
  logic fall_q, smp_q;

  // Sync flops reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_s1_q <= 1'b1;
      ps2_clk_s2_q <= 1'b1;
      ps2_clk_s3_q <= 1'b1;
      ps2_dat_s1_q <= 1'b1;
      ps2_dat_s2_q <= 1'b1;
      fall_q       <= 1'b0;
      smp_q        <= 1'b1;
    end else begin
      ps2_clk_s1_q <= ps2_clk;
      ps2_clk_s2_q <= ps2_clk_s1_q;
      ps2_clk_s3_q <= ps2_clk_s2_q;
      ps2_dat_s1_q <= ps2_data;
      ps2_dat_s2_q <= ps2_dat_s1_q;
      fall_q       <= ps2_clk_s3_q & ~ps2_clk_s2_q;
      smp_q        <= ps2_dat_s2_q;
    end
  end

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld_q, byte_vld_d;
  logic          bad_q, bad_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_vld_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_vld_q <= byte_vld_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = '0;
    byte_vld_d = 1'b0;
    bad_d      = 1'b0;

    if (state_q != S_IDLE && !fall_q) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        bad_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!smp_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            bad_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {smp_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = smp_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (smp_q && (^{shift_q, par_q})) byte_vld_d = 1'b1;
          else                              bad_d      = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic         ext_q, ext_d;
  logic         brk_q, brk_d;
  logic [8:0]   last_q, last_d;
  logic [511:0] keys_q, keys_d;
  logic         kdn_q, kdn_d;
  logic         kup_q, kup_d;
  logic         ferr_q, ferr_d;
  logic [8:0]   key_idx;

  assign key_idx = {ext_q, shift_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      last_q <= '0;
      keys_q <= '0;
      kdn_q  <= 1'b0;
      kup_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      last_q <= last_d;
      keys_q <= keys_d;
      kdn_q  <= kdn_d;
      kup_q  <= kup_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    last_d = last_q;
    keys_d = keys_q;
    kdn_d  = 1'b0;
    kup_d  = 1'b0;
    ferr_d = bad_q;

    if (bad_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          ext_d  = 1'b0;
          brk_d  = 1'b0;
          last_d = key_idx;
          if (brk_q) begin
            if (keys_q[key_idx]) begin
              keys_d[key_idx] = 1'b0;
              kup_d           = 1'b1;
            end
          end else if (!keys_q[key_idx]) begin
            keys_d[key_idx] = 1'b1;
            kdn_d           = 1'b1;
          end
        end
      endcase
    end
  end

  assign last_change       = last_q;
  assign key_down          = keys_q;
  assign key_down_onepulse = kdn_q;
  assign key_up_onepulse   = kup_q;
  assign frame_err         = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frame table, timeout/reset sequences and
// randomized frames checked against a scan-code level reference model.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [8:0]   last_change;
  logic         key_down_onepulse;
  logic         key_up_onepulse;
  logic [511:0] key_down;
  logic         frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .last_change(last_change), .key_down_onepulse(key_down_onepulse),
    .key_up_onepulse(key_up_onepulse), .key_down(key_down), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_dn = 0, n_up = 0, n_err = 0;

  // Reference model state
  logic         m_ext = 1'b0, m_brk = 1'b0;
  logic [8:0]   m_last = '0;
  logic [511:0] m_keys = '0;
  int           e_dn, e_up, e_err;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (key_down_onepulse) n_dn++;
      if (key_up_onepulse)   n_up++;
      if (frame_err)         n_err++;
      if (key_down_onepulse || key_up_onepulse || frame_err) begin
        checks++;
        if (int'(key_down_onepulse) + int'(key_up_onepulse) + int'(frame_err) > 1) begin
          errors++;
          $display("FAIL pulse_exclusive dn=%0b up=%0b err=%0b", key_down_onepulse,
                   key_up_onepulse, frame_err);
        end
      end
      if (key_down_onepulse) begin
        checks++;
        if (key_down[last_change] !== 1'b1) begin
          errors++;
          $display("FAIL held_with_pulse key=%0h actual=%0b expected=1", last_change,
                   key_down[last_change]);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(4);
  endtask

  function automatic bit is_nonkey(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hEE ||
           b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_apply(input logic [7:0] b, input bit bad);
    logic [8:0] k;
    e_dn = 0; e_up = 0; e_err = 0;
    if (bad) begin
      e_err = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (is_nonkey(b)) begin
      m_ext = 0; m_brk = 0;
    end else begin
      k = {m_ext, b};
      m_last = k;
      if (m_brk && m_keys[k]) begin
        m_keys[k] = 1'b0; e_up = 1;
      end else if (!m_brk && !m_keys[k]) begin
        m_keys[k] = 1'b1; e_dn = 1;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input logic stopv);
    logic par;
    par = ~(^b) ^ flip;
    n_dn = 0; n_up = 0; n_err = 0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stopv);
    ps2_data = 1'b1;
    wait_cyc(20);
    model_apply(b, flip || !stopv);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         flip;
    logic       stopv;
    logic [8:0] exp_last;
    int         exp_dn, exp_up, exp_err;
    logic [8:0] key;
    logic       key_val;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h69, 0, 1, 9'h069, 1, 0, 0, 9'h069, 1};
    vecs[1]  = '{8'h69, 0, 1, 9'h069, 0, 0, 0, 9'h069, 1};
    vecs[2]  = '{8'hE0, 0, 1, 9'h069, 0, 0, 0, 9'h15A, 0};
    vecs[3]  = '{8'h5A, 0, 1, 9'h15A, 1, 0, 0, 9'h15A, 1};
    vecs[4]  = '{8'hF0, 0, 1, 9'h15A, 0, 0, 0, 9'h069, 1};
    vecs[5]  = '{8'h69, 0, 1, 9'h069, 0, 1, 0, 9'h069, 0};
    vecs[6]  = '{8'hF0, 0, 1, 9'h069, 0, 0, 0, 9'h070, 0};
    vecs[7]  = '{8'h70, 0, 1, 9'h070, 0, 0, 0, 9'h070, 0};
    vecs[8]  = '{8'h7A, 1, 1, 9'h070, 0, 0, 1, 9'h07A, 0};
    vecs[9]  = '{8'h7A, 0, 1, 9'h07A, 1, 0, 0, 9'h07A, 1};
    vecs[10] = '{8'h12, 0, 0, 9'h07A, 0, 0, 1, 9'h012, 0};
    vecs[11] = '{8'h12, 0, 1, 9'h012, 1, 0, 0, 9'h012, 1};

    wait_cyc(5);
    chk("reset_last", 512'(last_change), 512'(9'h000));
    chk("reset_keys", key_down, '0);
    chk("reset_pulses", 512'({key_down_onepulse, key_up_onepulse, frame_err}), '0);
    rst = 1'b0;
    wait_cyc(5);

    foreach (vecs[i]) begin
      send_frame(vecs[i].b, vecs[i].flip, vecs[i].stopv);
      chk($sformatf("vec%0d_last", i), 512'(last_change), 512'(vecs[i].exp_last));
      chk($sformatf("vec%0d_dn", i), 512'(n_dn), 512'(vecs[i].exp_dn));
      chk($sformatf("vec%0d_up", i), 512'(n_up), 512'(vecs[i].exp_up));
      chk($sformatf("vec%0d_err", i), 512'(n_err), 512'(vecs[i].exp_err));
      chk($sformatf("vec%0d_key", i), 512'(key_down[vecs[i].key]), 512'(vecs[i].key_val));
    end

    // Partial frame abandoned by a long ps2_clk gap
    n_err = 0;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    wait_cyc(TMO + 10);
    chk("timeout_err", 512'(n_err), 512'(1));
    m_ext = 0; m_brk = 0;
    send_frame(8'h79, 0, 1);
    chk("after_tmo_last", 512'(last_change), 512'(9'h079));
    chk("after_tmo_dn", 512'(n_dn), 512'(1));

    // Reset in the middle of an E0 frame while a key is held
    send_frame(8'h69, 0, 1);
    chk("held_before_rst", 512'(key_down[9'h069]), 512'(1));
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    chk("rst_last", 512'(last_change), 512'(9'h000));
    chk("rst_keys", key_down, '0);
    m_ext = 0; m_brk = 0; m_last = '0; m_keys = '0;
    send_frame(8'h72, 0, 1);
    chk("post_rst_last", 512'(last_change), 512'(9'h072));
    chk("post_rst_dn", 512'(n_dn), 512'(1));

    // Random frames against the reference model
    for (int n = 0; n < 70; n++) begin
      int r;
      logic [7:0] keys4 [4];
      logic [7:0] nk [7];
      logic [7:0] b;
      bit   flip;
      logic stopv;
      keys4 = '{8'h69, 8'h70, 8'h5A, 8'h1C};
      nk    = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
      r = $urandom_range(0, 9);
      flip = 0; stopv = 1;
      b = keys4[$urandom_range(0, 3)];
      case (r)
        0, 1: b = 8'hE0;
        2, 3: b = 8'hF0;
        4: b = nk[$urandom_range(0, 6)];
        5: flip = ($urandom_range(0, 1) == 1);
        6: stopv = ($urandom_range(0, 1) == 1);
        default: ;
      endcase
      send_frame(b, flip, stopv);
      chk($sformatf("rnd%0d_last", n), 512'(last_change), 512'(m_last));
      chk($sformatf("rnd%0d_keys", n), key_down, m_keys);
      chk($sformatf("rnd%0d_pulses", n), 512'({n_dn, n_up, n_err}), 512'({e_dn, e_up, e_err}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
